// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD codes, FSM state encoding and digit classification types
package bcd_pkg;

    // Digit code driven by the display path for an unlit position
    localparam logic [3:0] BCD_BLANK     = 4'hF;
    // Largest legal decimal digit code
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } bcd_state_e;

    typedef struct packed {
        logic       is_digit;
        logic       is_leading_blank;
        logic       is_error;
        logic [3:0] value;
    } digit_class_t;

    // True for codes 0..9
    function automatic logic is_bcd_digit(input logic [3:0] code);
        return code <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/bcd_to_b16_if.sv
// rtl/bcd_to_b16_if.sv - request/result bundle between digit-entry logic and the converter
interface bcd_to_b16_if #(
    parameter int N_DIGITS = 5,
    parameter int OUT_W    = 16
);
    logic                  start;
    logic [4*N_DIGITS-1:0] bcd_in;
    logic                  busy;
    logic                  done;
    logic [OUT_W-1:0]      result;
    logic                  overflow;
    logic                  invalid;

    modport master (
        output start, bcd_in,
        input  busy, done, result, overflow, invalid
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, result, overflow, invalid
    );
endinterface

// File: rtl/bcd_digit_classify.sv
// rtl/bcd_digit_classify.sv - classifies one BCD code given whether a real digit was already seen
module bcd_digit_classify
    import bcd_pkg::*;
#(
    parameter logic [3:0] BLANK_CODE = BCD_BLANK
) (
    input  logic [3:0]   code,
    input  logic         seen_digit,
    output digit_class_t cls
);

    // Decimal digits pass through; blanks are zero until a digit appears, then illegal
    always_comb begin
        cls = '0;
        if (is_bcd_digit(code)) begin
            cls.is_digit = 1'b1;
            cls.value    = code;
        end else if (code == BLANK_CODE) begin
            cls.is_leading_blank = ~seen_digit;
            cls.is_error         = seen_digit;
        end else begin
            cls.is_error = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_to_b16.sv
// rtl/bcd_to_b16.sv - sequential BCD-to-binary converter, one digit per cycle, MS digit first
module bcd_to_b16
    import bcd_pkg::*;
#(
    parameter int         N_DIGITS   = 5,
    parameter int         OUT_W      = 16,
    parameter logic [3:0] BLANK_CODE = BCD_BLANK
) (
    input  logic         clk,
    input  logic         rst_n,
    bcd_to_b16_if.slave  bus
);

    localparam int ACC_W = $clog2(10 ** N_DIGITS);
    localparam int IDX_W = $clog2(N_DIGITS + 1);
    localparam int SR_W  = 4 * N_DIGITS;
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
    localparam logic [CMP_W-1:0] SAT_LIM  = (CMP_W'(1) << OUT_W) - CMP_W'(1);

    bcd_state_e       state_q;
    bcd_state_e       state_nxt;

    logic [SR_W-1:0]  shift_q;
    logic [IDX_W-1:0] idx_q;
    logic [ACC_W-1:0] acc_q;
    logic             seen_q;
    logic             err_q;

    logic [OUT_W-1:0] result_q;
    logic             ovf_q;
    logic             inv_q;

    digit_class_t     cls;
    logic [ACC_W-1:0] acc_nxt;
    logic             seen_nxt;
    logic             err_nxt;
    logic             last_digit;

    logic [OUT_W-1:0] fin_result;
    logic             fin_ovf;
    logic             fin_inv;

    logic             busy_c;
    logic             done_c;

    bcd_digit_classify #(
        .BLANK_CODE (BLANK_CODE)
    ) u_classify (
        .code       (shift_q[SR_W-1 -: 4]),
        .seen_digit (seen_q),
        .cls        (cls)
    );

    assign last_digit = (idx_q == LAST_IDX);
    assign seen_nxt   = seen_q | cls.is_digit;
    assign err_nxt    = err_q | cls.is_error;

    // Accumulate acc*10 + digit with shifts; a leading blank keeps the running value at zero
    always_comb begin
        acc_nxt = (acc_q << 3) + (acc_q << 1) + ACC_W'(cls.value);
        if (cls.is_leading_blank) begin
            acc_nxt = '0;
        end
    end

    // Final value after the last digit: error beats overflow beats plain result
    always_comb begin
        fin_result = OUT_W'(acc_nxt);
        fin_ovf    = 1'b0;
        fin_inv    = 1'b0;
        if (err_nxt) begin
            fin_result = '0;
            fin_inv    = 1'b1;
        end else if (CMP_W'(acc_nxt) > SAT_LIM) begin
            fin_result = '1;
            fin_ovf    = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state: start only matters in IDLE, DONE lasts a single cycle
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (bus.start)  state_nxt = ST_CONV;
            ST_CONV: if (last_digit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state_q)
            ST_CONV: busy_c = 1'b1;
            ST_DONE: done_c = 1'b1;
            default: ;
        endcase
    end

    // Digit shift register, index, accumulator and held result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q  <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            seen_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_q <= bus.bcd_in;
                        idx_q   <= '0;
                        acc_q   <= '0;
                        seen_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ST_CONV: begin
                    shift_q <= shift_q << 4;
                    idx_q   <= idx_q + IDX_W'(1);
                    acc_q   <= acc_nxt;
                    seen_q  <= seen_nxt;
                    err_q   <= err_nxt;
                    if (last_digit) begin
                        result_q <= fin_result;
                        ovf_q    <= fin_ovf;
                        inv_q    <= fin_inv;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
    assign bus.invalid  = inv_q;

endmodule

// File: tb/tb_bcd_to_b16.sv
// tb/tb_bcd_to_b16.sv - randomized self-checking bench for bcd_to_b16 against a decimal model
module tb_bcd_to_b16;

    localparam int ND = 5;
    localparam int OW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_to_b16_if #(.N_DIGITS(ND), .OUT_W(OW)) bus ();

    bcd_to_b16 #(.N_DIGITS(ND), .OUT_W(OW), .BLANK_CODE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decimal reading of the digit string: leading blanks are zeros, any other non-digit is an error
    function automatic void ref_model(input logic [19:0] bcd, output logic [15:0] r,
                                      output logic ov, output logic inv);
        int  value = 0;
        bit  seen  = 0;
        bit  bad   = 0;
        int  d;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(bcd[4*i +: 4]);
            if (d <= 9) begin
                value = value * 10 + d;
                seen  = 1;
            end else if (d == 15) begin
                if (seen) bad = 1;
            end else begin
                bad = 1;
            end
        end
        if (bad) begin
            r = 16'd0; ov = 1'b0; inv = 1'b1;
        end else if (value > 65535) begin
            r = 16'hFFFF; ov = 1'b1; inv = 1'b0;
        end else begin
            r = 16'(value); ov = 1'b0; inv = 1'b0;
        end
    endfunction

    // One conversion; with noise, start and bcd_in are disturbed during CONV and DONE
    task automatic run_conv(input logic [19:0] bcd, input bit noise, input string tag);
        logic [15:0] er;
        logic        eo, ei;
        int          lat;
        ref_model(bcd, er, eo, ei);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        while (lat <= 20) begin
            if (noise) begin
                bus.start  = 1'($urandom);
                bus.bcd_in = 20'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) break;
        end
        check({tag, "_latency"}, 32'(lat), 32'(ND));
        if (lat > 20) return;
        check({tag, "_result"}, 32'(bus.result), 32'(er));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(eo));
        check({tag, "_invalid"}, 32'(bus.invalid), 32'(ei));
        bus.start = noise ? 1'b1 : 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_done_pulse"}, {30'd0, bus.done, bus.busy}, 32'd0);
        if (noise) begin
            @(negedge clk);
            check({tag, "_start_in_done_ignored"}, {30'd0, bus.done, bus.busy}, 32'd0);
            check({tag, "_result_held"}, 32'(bus.result), 32'(er));
        end
    endtask

    initial begin
        int dones;
        logic [19:0] bcd;

        bus.start  = 1'b0;
        bus.bcd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_flags", {30'd0, bus.overflow, bus.invalid}, 32'd0);
        rst_n = 1'b1;

        run_conv(20'h12345, 1'b0, "d12345");
        check("d12345_const", 32'(bus.result), 32'd12345);
        run_conv(20'h65535, 1'b0, "d65535");
        run_conv(20'h65536, 1'b0, "d65536");
        run_conv(20'hFFF42, 1'b0, "lead_blank");
        run_conv(20'hFFFFF, 1'b0, "all_blank");
        run_conv(20'h1F300, 1'b0, "embed_blank");
        run_conv(20'h99A99, 1'b0, "code_a");
        run_conv(20'h99999, 1'b0, "d99999");
        run_conv(20'h00042, 1'b1, "noise");

        // Reset in the third CONV cycle must abort with no done pulse
        run_conv(20'h12345, 1'b0, "pre_rst");
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 20'h54321;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_status", {30'd0, bus.done, bus.busy}, 32'd0);
        check("midrst_result", 32'(bus.result), 32'd0);
        check("midrst_flags", {30'd0, bus.overflow, bus.invalid}, 32'd0);
        rst_n = 1'b1;
        dones = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_conv(20'h54321, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            bcd = '0;
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i < ND; i++) bcd[4*i +: 4] = 4'($urandom_range(0, 9));
            end else begin
                for (int i = 0; i < ND; i++) begin
                    if ($urandom_range(0, 2) == 0) bcd[4*i +: 4] = 4'hF;
                    else                           bcd[4*i +: 4] = 4'($urandom_range(0, 15));
                end
            end
            run_conv(bcd, $urandom_range(0, 3) == 0, $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
